wb_spi_regs: RTL and testbench

WB_SPI_REGS -- requirements
Module: wb_spi_regs

---
 rtl/wb_spi_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/wb_spi_regs.sv | 187 ++++++++++++++++++
 tb/tb_wb_spi_regs.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_pkg
// Description : Shared register map, CTRL/STATUS bit positions and bus FSM
//               state encodings for the Wishbone SPI register block.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_spi_pkg;

    localparam logic [2:0] c_ADR_CTRL    = 3'h0;
    localparam logic [2:0] c_ADR_STATUS  = 3'h1;
    localparam logic [2:0] c_ADR_TXDATA  = 3'h2;
    localparam logic [2:0] c_ADR_RXDATA  = 3'h3;
    localparam logic [2:0] c_ADR_SCRATCH = 3'h4;

    localparam int c_CTRL_EN       = 0;
    localparam int c_CTRL_TX_FLUSH = 1;
    localparam int c_CTRL_RX_FLUSH = 2;

    localparam int c_STAT_TX_FULL  = 0;
    localparam int c_STAT_TX_EMPTY = 1;
    localparam int c_STAT_RX_FULL  = 2;
    localparam int c_STAT_RX_EMPTY = 3;
    localparam int c_STAT_RX_OVF   = 4;
    localparam int c_STAT_TX_OVF   = 5;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with flush; flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign w_do_push = i_push && !full  && !i_flush;
    assign w_do_pop  = i_pop  && !empty && !i_flush;

    assign full   = (r_count == c_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign o_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_spi_regs.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_regs
// Description : Wishbone register block with TX/RX FIFOs for an SPI core.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_spi_regs #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADR_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADR_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid
);

    import wb_spi_pkg::*;

    localparam int         c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_STATES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [3:0]            r_wait_cnt;
    logic                  r_ack;
    logic                  w_ack_next;
    logic                  w_enter_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_scratch;
    logic                  r_rx_ovf;
    logic                  r_tx_ovf;

    logic                  w_adr_ok;
    logic [2:0]            w_sel;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic                  w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
    logic                  w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
    logic [DATA_WIDTH-1:0] w_rx_head;
    logic [c_CNT_W-1:0]    w_tx_count;
    logic [c_CNT_W-1:0]    w_rx_count;
    logic                  w_unused;

    assign w_unused = &{1'b0, cyc_i, w_tx_count, w_rx_count};

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ack      <= w_ack_next;
            r_wait_cnt <= (r_state == c_ST_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (stb_i) w_state_next = (WAIT_STATES > 0) ? c_ST_WAIT : c_ST_ACK;
            c_ST_WAIT: if (r_wait_cnt == c_WAIT_LAST) w_state_next = c_ST_ACK;
            c_ST_ACK:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ack_next  = (w_state_next == c_ST_ACK);
        w_enter_ack = w_ack_next && (r_state != c_ST_ACK);
    end

    assign ack_o = r_ack;
    assign dat_o = r_dat;

    // ---------------- address decode ----------------
    // Any address bit above [2:0] turns the access into an acked no-op.
    assign w_adr_ok   = ((adr_i >> 3) == '0);
    assign w_sel      = adr_i[2:0];
    assign w_wr       = w_enter_ack && we_i  && w_adr_ok;
    assign w_rd       = w_enter_ack && !we_i && w_adr_ok;

    assign w_tx_push  = w_wr && (w_sel == c_ADR_TXDATA);
    assign w_tx_flush = w_wr && (w_sel == c_ADR_CTRL) && dat_i[c_CTRL_TX_FLUSH];
    assign w_rx_flush = w_wr && (w_sel == c_ADR_CTRL) && dat_i[c_CTRL_RX_FLUSH];
    assign w_rx_pop   = w_rd && (w_sel == c_ADR_RXDATA);
    assign tx_valid   = r_en && !w_tx_empty;
    assign w_tx_pop   = tx_valid && tx_ready;

    always_comb begin
        w_rd_data = '0;
        if (w_adr_ok) begin
            case (w_sel)
                c_ADR_CTRL:    w_rd_data[c_CTRL_EN] = r_en;
                c_ADR_STATUS: begin
                    w_rd_data[c_STAT_TX_FULL]  = w_tx_full;
                    w_rd_data[c_STAT_TX_EMPTY] = w_tx_empty;
                    w_rd_data[c_STAT_RX_FULL]  = w_rx_full;
                    w_rd_data[c_STAT_RX_EMPTY] = w_rx_empty;
                    w_rd_data[c_STAT_RX_OVF]   = r_rx_ovf;
                    w_rd_data[c_STAT_TX_OVF]   = r_tx_ovf;
                end
                c_ADR_RXDATA:  w_rd_data = w_rx_empty ? '0 : w_rx_head;
                c_ADR_SCRATCH: w_rd_data = r_scratch;
                default:       w_rd_data = '0;
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat     <= '0;
            r_en      <= 1'b0;
            r_scratch <= '0;
            r_rx_ovf  <= 1'b0;
            r_tx_ovf  <= 1'b0;
        end else begin
            if (w_enter_ack) begin
                r_dat <= we_i ? '0 : w_rd_data;
            end
            if (w_wr && (w_sel == c_ADR_CTRL)) begin
                r_en <= dat_i[c_CTRL_EN];
            end
            if (w_wr && (w_sel == c_ADR_SCRATCH)) begin
                r_scratch <= dat_i;
            end
            // A fresh overflow outranks a same-cycle clear so no event is lost.
            if (w_wr && (w_sel == c_ADR_STATUS) && dat_i[c_STAT_RX_OVF]) begin
                r_rx_ovf <= 1'b0;
            end
            if (rx_valid && w_rx_full) begin
                r_rx_ovf <= 1'b1;
            end
            if (w_wr && (w_sel == c_ADR_STATUS) && dat_i[c_STAT_TX_OVF]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_tx_push && w_tx_full) begin
                r_tx_ovf <= 1'b1;
            end
        end
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_tx_flush),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (dat_i),
        .o_data  (tx_data),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .count   (w_tx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_rx_flush),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_data  (rx_data),
        .o_data  (w_rx_head),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .count   (w_rx_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_spi_regs
// Description : Directed self-checking bench for wb_spi_regs (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spi_regs;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr_i = '0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  txq[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  wdat;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[20];

    wb_spi_regs #(.DATA_WIDTH(8), .ADR_WIDTH(32), .FIFO_DEPTH(4), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .cyc_i    (cyc_i),
        .stb_i    (stb_i),
        .we_i     (we_i),
        .ack_o    (ack_o),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    // Each negedge with a live handshake is one byte leaving on the next posedge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called and returns at posedge+1. mid_rdy raises tx_ready only across the ACK-entry edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [7:0] d,
                        input logic mid_rdy, output logic [7:0] q);
        int lat;
        adr_i = a; we_i = w; dat_i = d; stb_i = 1'b1; cyc_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (mid_rdy && lat == 1) tx_ready = 1'b1;
        end while (!ack_o && lat < 20);
        q = dat_o;
        stb_i = 1'b0; cyc_i = 1'b0;
        if (mid_rdy) tx_ready = 1'b0;
        check("ack_latency", lat, 1 + WS);
        @(posedge clk); #1;
        check("ack_width", {31'b0, ack_o}, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        logic [7:0] q;
        xfer(1'b1, a, d, 1'b0, q);
        check("write_dat_o", q, 0);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [7:0] exp);
        logic [7:0] q;
        xfer(1'b0, a, 8'h00, 1'b0, q);
        check(name, q, exp);
    endtask

    task automatic check_txq(input logic [31:0] exp_word);
        check("tx_stream_len", txq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < txq.size()) ? txq[i] : 8'h00;
            check("tx_stream_byte", got, exp_word[31-8*i -: 8]);
        end
    endtask

    initial begin
        logic [7:0] q;
        int lat;

        vecs[0]  = '{1'b0, 32'h0000_0001, 8'h00, 8'h0A};
        vecs[1]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 32'h0000_0004, 8'hA5, 8'h00};
        vecs[3]  = '{1'b0, 32'h0000_0004, 8'h00, 8'hA5};
        vecs[4]  = '{1'b1, 32'h0000_0000, 8'hFF, 8'h00};
        vecs[5]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h01};
        vecs[6]  = '{1'b1, 32'h0000_0000, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 32'h0000_0006, 8'hFF, 8'h00};
        vecs[9]  = '{1'b0, 32'h0000_0006, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 32'h0000_0004, 8'h00, 8'hA5};
        vecs[11] = '{1'b1, 32'h0000_0014, 8'h3C, 8'h00};
        vecs[12] = '{1'b0, 32'h0000_0004, 8'h00, 8'hA5};
        vecs[13] = '{1'b0, 32'h8000_0004, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 32'h0000_0003, 8'h99, 8'h00};
        vecs[15] = '{1'b0, 32'h0000_0003, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 32'h0000_0002, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 32'h0000_0001, 8'h00, 8'h0A};
        vecs[18] = '{1'b0, 32'h0000_0005, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 32'h0000_0007, 8'h00, 8'h00};

        #1 rst = 1'b1;
        #2;
        check("rst_ack", {31'b0, ack_o}, 0);
        check("rst_dat_o", dat_o, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, 1'b0, q);
            check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // TX fill with en=0, one RX byte parked so STATUS shows only tx_full|tx_ovf.
        tx_ready = 1'b1;
        rx_data = 8'hEE; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        wr(32'h2, 8'h11); wr(32'h2, 8'h22); wr(32'h2, 8'h33); wr(32'h2, 8'h44); wr(32'h2, 8'h55);
        check("tx_valid_en0", {31'b0, tx_valid}, 0);
        rd("status_txfull_ovf", 32'h1, 8'h21);
        rd("rx_parked", 32'h3, 8'hEE);
        txq.delete();
        wr(32'h0, 8'h01);
        repeat (8) @(posedge clk);
        #1;
        check_txq(32'h11223344);
        rd("status_tx_drained", 32'h1, 8'h2A);
        wr(32'h1, 8'h20);
        rd("status_txovf_clr", 32'h1, 8'h0A);

        // RX overflow and drain.
        for (int i = 1; i <= 5; i++) begin
            rx_data = 8'(i); rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rd("status_rx_ovf", 32'h1, 8'h16);
        for (int i = 1; i <= 4; i++) rd("rx_pop", 32'h3, 8'(i));
        rd("rx_pop_empty", 32'h3, 8'h00);
        rd("status_rx_empty", 32'h1, 8'h1A);
        wr(32'h1, 8'h10);
        rd("status_rxovf_clr", 32'h1, 8'h0A);

        // Simultaneous push/pop on a 2-entry TX FIFO, then flush.
        tx_ready = 1'b0;
        wr(32'h2, 8'hA1); wr(32'h2, 8'hA2);
        check("tx_head", {24'b0, tx_data}, 8'hA1);
        txq.delete();
        xfer(1'b1, 32'h2, 8'hA3, 1'b1, q);
        check("pushpop_pops", txq.size(), 1);
        check("pushpop_byte", (txq.size() > 0) ? {24'b0, txq[0]} : 32'hFFFF, 8'hA1);
        rd("status_cnt2", 32'h1, 8'h08);
        wr(32'h2, 8'hA4); wr(32'h2, 8'hA5);
        rd("status_cnt4_full", 32'h1, 8'h09);
        txq.delete();
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check_txq(32'hA2A3A4A5);
        wr(32'h2, 8'hB1); wr(32'h2, 8'hB2);
        rd("status_pre_flush", 32'h1, 8'h08);
        wr(32'h0, 8'h03);
        check("flush_tx_valid", {31'b0, tx_valid}, 0);
        rd("status_post_flush", 32'h1, 8'h0A);
        rd("ctrl_selfclear", 32'h0, 8'h01);

        // Reset in WAIT during a SCRATCH write; held stb becomes a new read.
        adr_i = 32'h4; we_i = 1'b1; dat_i = 8'h77; stb_i = 1'b1; cyc_i = 1'b1;
        @(posedge clk); #1;
        check("wait_no_ack", {31'b0, ack_o}, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'b0, ack_o}, 0);
        check("rst_mid_dat_o", dat_o, 0);
        check("rst_mid_tx_valid", {31'b0, tx_valid}, 0);
        we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_hold_ack", {31'b0, ack_o}, 0);
        end
        rst = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack_o && lat < 20);
        check("post_rst_latency", lat, 1 + WS);
        check("scratch_after_rst", dat_o, 0);
        stb_i = 1'b0; cyc_i = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack_width", {31'b0, ack_o}, 0);
        rd("ctrl_after_rst", 32'h0, 8'h00);
        rd("status_after_rst", 32'h1, 8'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
